// File: rtl/sn74_nibble_demux.sv
// sn74_nibble_demux
//   Receive side of a time-multiplexed nibble bus (74xx257 style). The source
//   sends nibble A (sel=1) then nibble B (sel=0) on one shared bus, qualified
//   by an active-low output enable. Each A/B pair is reassembled into {B, A}
//   and presented on a one-deep valid/ready output register. Out-of-order
//   beats and words dropped against a full output are flagged and counted.
//
// Ports
//   clk, rst_n        rising-edge clock, async active-low reset
//   bus[WIDTH]        multiplexed nibble bus, sampled only when oe_n=0
//   sel               1 = nibble A (low half), 0 = nibble B (high half)
//   oe_n              0 = beat this cycle, 1 = bus floating / ignored
//   clr               sync clear of seq_err, overrun, err_cnt (wins over set)
//   dout[2*WIDTH]     assembled word {B, A}
//   dout_valid        dout holds an unconsumed word
//   dout_ready        consumer handshake
//   busy              A captured, waiting for B
//   seq_err, overrun  sticky error flags
//   err_cnt[ERRW]     saturating count of sequence errors plus overruns
module sn74_nibble_demux #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   bus,
  input  logic               sel,
  input  logic               oe_n,
  input  logic               clr,
  output logic [2*WIDTH-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               seq_err,
  output logic               overrun,
  output logic [ERRW-1:0]    err_cnt
);

  typedef enum logic {IDLE = 1'b0, GOT_A = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               seq_err_q, seq_err_d;
  logic               overrun_q, overrun_d;
  logic [ERRW-1:0]    err_cnt_q, err_cnt_d;

  logic beat, complete, seq_hit, ovr_hit, consume;

  // Sequencer: bus is only looked at on a beat, so X/Z while floating
  // never reaches state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    complete = 1'b0;
    seq_hit  = 1'b0;
    beat     = ~oe_n;
    if (beat) begin
      unique case (state_q)
        IDLE: begin
          if (sel) begin
            a_d     = bus;
            state_d = GOT_A;
          end else begin
            seq_hit = 1'b1;            // B without A: nibble discarded
          end
        end
        GOT_A: begin
          if (sel) begin
            seq_hit = 1'b1;            // repeated A: newest A wins
            a_d     = bus;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-deep output register. A same-cycle consume frees the slot, so a
  // completion can load straight over the word being taken.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovr_hit      = 1'b0;
    consume      = dout_valid_q & dout_ready;
    if (complete && (!dout_valid_q || consume)) begin
      dout_d       = {bus, a_q};
      dout_valid_d = 1'b1;
    end else if (complete) begin
      ovr_hit = 1'b1;                  // keep old word, drop the new one
    end else if (consume) begin
      dout_valid_d = 1'b0;
    end
  end

  // Error bookkeeping. seq_hit and ovr_hit are mutually exclusive (an error
  // beat never completes a word), so at most one increment per cycle.
  always_comb begin
    seq_err_d = seq_err_q | seq_hit;
    overrun_d = overrun_q | ovr_hit;
    err_cnt_d = err_cnt_q;
    if ((seq_hit || ovr_hit) && (err_cnt_q != {ERRW{1'b1}}))
      err_cnt_d = err_cnt_q + ERRW'(1);
    if (clr) begin
      seq_err_d = 1'b0;
      overrun_d = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      seq_err_q    <= seq_err_d;
      overrun_q    <= overrun_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == GOT_A);
  assign seq_err    = seq_err_q;
  assign overrun    = overrun_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sn74_nibble_demux.sv
module tb_sn74_nibble_demux;
  localparam int W      = 4;
  localparam int ERRW   = 8;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     bus = '0;
  logic             sel = 1'b0;
  logic             oe_n = 1'b1;
  logic             clr = 1'b0;
  logic [2*W-1:0]   dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             busy;
  logic             seq_err;
  logic             overrun;
  logic [ERRW-1:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference model state: pending A nibble, one-slot output, error tallies
  bit m_have_a;
  int m_a;
  bit m_full;
  int m_dout;
  bit m_seq;
  bit m_ovr;
  int m_cnt;

  sn74_nibble_demux #(.WIDTH(W), .ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sel(sel), .oe_n(oe_n), .clr(clr),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .seq_err(seq_err), .overrun(overrun), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_have_a = 0; m_a = 0; m_full = 0; m_dout = 0;
    m_seq = 0; m_ovr = 0; m_cnt = 0;
  endfunction

  // One clock of protocol behaviour, from the rules as written.
  function automatic void m_step(bit oe_i, bit sel_i, int bus_i, bit rdy_i, bit clr_i);
    bit consume = m_full && rdy_i;
    bit done = 0;
    bit serr = 0;
    bit ovr = 0;
    int word = 0;
    if (!oe_i) begin
      if (sel_i) begin
        if (m_have_a) serr = 1;
        m_have_a = 1;
        m_a = bus_i;
      end else if (!m_have_a) begin
        serr = 1;
      end else begin
        done = 1;
        word = (bus_i << W) | m_a;
        m_have_a = 0;
      end
    end
    if (consume) m_full = 0;
    if (done) begin
      if (m_full) ovr = 1;
      else begin m_full = 1; m_dout = word; end
    end
    if (serr || ovr) m_cnt = (m_cnt >= ERRMAX) ? ERRMAX : m_cnt + 1;
    m_seq = m_seq | serr;
    m_ovr = m_ovr | ovr;
    if (clr_i) begin m_seq = 0; m_ovr = 0; m_cnt = 0; end
  endfunction

  task automatic cmp_all(input string tag);
    chk({tag, ".dv"},   32'(dout_valid), 32'(m_full));
    chk({tag, ".dout"}, 32'(dout),       32'(m_dout));
    chk({tag, ".busy"}, 32'(busy),       32'(m_have_a));
    chk({tag, ".serr"}, 32'(seq_err),    32'(m_seq));
    chk({tag, ".ovr"},  32'(overrun),    32'(m_ovr));
    chk({tag, ".cnt"},  32'(err_cnt),    32'(m_cnt));
  endtask

  // Drive one cycle, clock it, advance the model, compare 1ns after the edge.
  task automatic cyc(input string tag, input bit oe_i, input bit sel_i,
                     input int bus_i, input bit rdy_i, input bit clr_i);
    oe_n = oe_i; sel = sel_i; bus = W'(bus_i); dout_ready = rdy_i; clr = clr_i;
    @(posedge clk);
    m_step(oe_i, sel_i, bus_i, rdy_i, clr_i);
    #1;
    cmp_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy_i);
    cyc(tag, 1'b1, 1'b0, int'($urandom_range(0, 15)), rdy_i, 1'b0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all("rst");
    @(negedge clk) rst_n = 1'b1;
    #1;

    // basic pair, ready held high
    cyc("a",    0, 1, 4'ha, 1, 0);
    chk("basic.busy_between", 32'(busy), 1);
    cyc("b",    0, 0, 4'hf, 1, 0);
    chk("basic.dout", 32'(dout), 32'hfa);
    chk("basic.dv",   32'(dout_valid), 1);
    idle("post", 1);
    chk("basic.dv_drop", 32'(dout_valid), 0);

    // idle gaps with bus=0 during the gaps
    cyc("ga", 0, 1, 4'ha, 1, 0);
    repeat (3) cyc("gap", 1, 0, 0, 1, 0);
    cyc("gb", 0, 0, 4'hf, 1, 0);
    chk("gap.dout", 32'(dout), 32'hfa);
    chk("gap.cnt",  32'(err_cnt), 0);

    // sequence errors
    cyc("lb", 0, 0, 4'h3, 1, 0);
    chk("seq.lead_b", 32'(err_cnt), 1);
    cyc("a1", 0, 1, 4'h1, 1, 0);
    cyc("a2", 0, 1, 4'h2, 1, 0);
    cyc("b4", 0, 0, 4'h4, 1, 0);
    chk("seq.cnt2", 32'(err_cnt), 2);
    chk("seq.dout", 32'(dout), 32'h42);

    // overrun with ready low
    cyc("clr0", 1, 0, 0, 1, 1);
    cyc("o1a", 0, 1, 1, 0, 0);
    cyc("o1b", 0, 0, 2, 0, 0);
    cyc("o2a", 0, 1, 3, 0, 0);
    cyc("o2b", 0, 0, 4, 0, 0);
    chk("ovr.dout", 32'(dout), 32'h21);
    chk("ovr.flag", 32'(overrun), 1);
    chk("ovr.cnt",  32'(err_cnt), 1);
    idle("ovr.drain", 1);
    chk("ovr.dv0", 32'(dout_valid), 0);

    // consume and complete in the same cycle
    cyc("c1a", 0, 1, 1, 0, 0);
    cyc("c1b", 0, 0, 2, 0, 0);
    cyc("c2a", 0, 1, 5, 0, 0);
    cyc("c2b", 0, 0, 6, 1, 0);
    chk("coin.dout", 32'(dout), 32'h65);
    chk("coin.dv",   32'(dout_valid), 1);
    chk("coin.ovr",  32'(overrun), 1);   // still sticky from previous section
    cyc("clr1", 1, 0, 0, 1, 1);
    chk("clr.ovr", 32'(overrun), 0);

    // async reset mid-pair
    cyc("ra", 0, 1, 4'h7, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.busy", 32'(busy), 0);
    chk("arst.dout", 32'(dout), 0);
    chk("arst.dv",   32'(dout_valid), 0);
    cmp_all("arst");
    @(negedge clk) rst_n = 1'b1;
    cyc("rb", 0, 0, 4'h9, 1, 0);
    chk("arst.serr_b", 32'(seq_err), 1);

    // saturation
    for (int i = 0; i < ERRMAX + 4; i++) cyc("sat", 0, 0, i & 15, 1, 0);
    chk("sat.cnt", 32'(err_cnt), ERRMAX);
    // clr against a same-cycle error: clear wins
    cyc("clrw", 0, 0, 1, 1, 1);
    chk("clr.cnt",  32'(err_cnt), 0);
    chk("clr.serr", 32'(seq_err), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit o = ($urandom_range(0, 9) < 3);
      bit s = $urandom_range(0, 1);
      bit r = ($urandom_range(0, 3) != 0);
      bit c = ($urandom_range(0, 49) == 0);
      cyc("rnd", o, s, int'($urandom_range(0, 15)), r, c);
    end
    // mostly well-formed pairs to exercise throughput and overrun
    for (int i = 0; i < 200; i++) begin
      bit r = $urandom_range(0, 1);
      cyc("pa", 0, 1, int'($urandom_range(0, 15)), r, 0);
      cyc("pb", 0, 0, int'($urandom_range(0, 15)), r, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
